// File: rtl/ifetch_prefetch_if.sv
// Fetch-unit bus bundle: SDRAM instruction-port request/response, redirect input,
// and the decode-side valid/ready instruction stream.
interface ifetch_prefetch_if #(
  parameter int ADDR_W = 25
);
  logic              mem_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [31:0]       mem_result;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              fetch_fault;

  modport master (
    output mem_enable, mem_addr, inst_valid, inst_data, inst_pc, fetch_fault,
    input  mem_valid, mem_result, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_enable, mem_addr, inst_valid, inst_data, inst_pc, fetch_fault,
    output mem_valid, mem_result, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: one outstanding SDRAM read at a time, words tagged with
// their PC in a small FIFO toward decode; redirects flush and drain in-flight reads.
module ifetch_prefetch #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 25,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  ifetch_prefetch_if.master   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FAULT} state_t;

  state_t            state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              fault_q, fault_d;
  logic              push, pop, flush, misaligned, has_room, inst_valid;

  entry_t            fifo [DEPTH];
  entry_t            head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  assign misaligned = bus.redirect_pc[1:0] != 2'b00;
  assign has_room   = count < CW'(DEPTH);
  assign inst_valid = count != '0;
  assign head       = fifo[rd_ptr];
  // Redirect wins: a same-cycle pop is dropped along with the rest of the FIFO.
  assign pop        = inst_valid && bus.inst_ready && !bus.redirect_valid;

  always_comb begin
    state_d    = state_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (has_room) begin
          state_d    = REQ;
          mem_en_d   = 1'b1;
          mem_addr_d = fetch_pc_q;
        end else begin
          mem_en_d = 1'b0;
        end
      end
      REQ: begin
        if (bus.mem_valid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          mem_en_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        mem_en_d = 1'b0;
        if (bus.mem_valid) state_d = fault_q ? FAULT : IDLE;
      end
      FAULT:   mem_en_d = 1'b0;
      default: state_d  = IDLE;
    endcase

    if (bus.redirect_valid) begin
      flush      = 1'b1;
      push       = 1'b0;
      mem_en_d   = 1'b0;
      fetch_pc_d = bus.redirect_pc;
      fault_d    = misaligned;
      // A read the controller already latched must still be drained; if its pulse
      // lands on this very cycle it is dropped here instead.
      if ((state_q == REQ || state_q == DRAIN) && !bus.mem_valid)
        state_d = DRAIN;
      else
        state_d = misaligned ? FAULT : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: fetch_pc_q, data: bus.mem_result};
  end

  assign bus.mem_enable  = mem_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.inst_valid  = inst_valid;
  assign bus.inst_data   = inst_valid ? head.data : 32'h0;
  assign bus.inst_pc     = inst_valid ? head.pc : '0;
  assign bus.fetch_fault = fault_q;
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch against a latency-9 instruction memory model
// that returns addr | 0xA5000000.
module tb_ifetch_prefetch;
  localparam int ADDR_W = 25;
  localparam int LAT    = 9;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  ifetch_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

  ifetch_prefetch #(.DEPTH(4), .ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: latches a request on the first negedge it sees enable while idle,
  // then pulses valid for one cycle LAT negedges later.
  bit                busy = 1'b0;
  int                lat  = 0;
  logic [ADDR_W-1:0] laddr;
  always @(negedge clk) begin
    if (mon_en && rst_n && bus.mem_valid) chk("enable_after_valid", 32'(bus.mem_enable), 32'd0);
    bus.mem_valid  = 1'b0;
    bus.mem_result = 32'hDEAD_BEEF;
    if (busy) begin
      lat--;
      if (lat == 0) begin
        bus.mem_valid  = 1'b1;
        bus.mem_result = {7'b0, laddr} | 32'hA500_0000;
        busy = 1'b0;
      end
    end else if (bus.mem_enable) begin
      busy  = 1'b1;
      lat   = LAT;
      laddr = bus.mem_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for the head, check it, then spend one cycle so inst_ready=1 pops it.
  task automatic expect_inst(input string tag, input logic [ADDR_W-1:0] pc, input logic [31:0] data);
    int n = 0;
    while (!bus.inst_valid && n < 200) begin step(); n++; end
    chk({tag, " valid"}, 32'(bus.inst_valid), 32'd1);
    chk({tag, " pc"},    32'(bus.inst_pc),    32'(pc));
    chk({tag, " data"},  bus.inst_data,       data);
    step();
  endtask

  task automatic wait_enable(input string tag);
    int n = 0;
    while (!bus.mem_enable && n < 200) begin step(); n++; end
    chk({tag, " enable"}, 32'(bus.mem_enable), 32'd1);
  endtask

  task automatic redirect(input logic [ADDR_W-1:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    int n;
    rst_n              = 1'b0;
    bus.mem_valid      = 1'b0;
    bus.mem_result     = 32'hDEAD_BEEF;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    #12;
    chk("rst mem_enable",  32'(bus.mem_enable),  32'd0);
    chk("rst mem_addr",    32'(bus.mem_addr),    32'd0);
    chk("rst inst_valid",  32'(bus.inst_valid),  32'd0);
    chk("rst inst_data",   bus.inst_data,        32'd0);
    chk("rst inst_pc",     32'(bus.inst_pc),     32'd0);
    chk("rst fetch_fault", 32'(bus.fetch_fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Backpressure: four words buffer up, then no further requests.
    repeat (60) step();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin seen |= bus.mem_enable; step(); end
    chk("stall no enable", 32'(seen), 32'd0);
    chk("stall head pc",   32'(bus.inst_pc), 32'h0);
    chk("stall head valid", 32'(bus.inst_valid), 32'd1);

    bus.inst_ready = 1'b1;
    expect_inst("seq0",  25'h0,  32'hA500_0000);
    expect_inst("seq4",  25'h4,  32'hA500_0004);
    expect_inst("seq8",  25'h8,  32'hA500_0008);
    expect_inst("seq12", 25'hC,  32'hA500_000C);
    expect_inst("seq16", 25'h10, 32'hA500_0010);

    // Redirect while a read is in flight: its word must never surface.
    wait_enable("mid");
    step();
    redirect(25'h100);
    chk("mid flush valid",  32'(bus.inst_valid), 32'd0);
    chk("mid enable off",   32'(bus.mem_enable), 32'd0);
    expect_inst("mid 0x100", 25'h100, 32'hA500_0100);

    // Redirect coinciding with mem_valid, a push and a pop.
    bus.inst_ready = 1'b0;
    n = 0;
    while (!bus.inst_valid && n < 200) begin step(); n++; end
    chk("coin buffered", 32'(bus.inst_valid), 32'd1);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.mem_valid && n < 200);
    chk("coin mem_valid", 32'(bus.mem_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 25'h40;
    bus.inst_ready     = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    chk("coin flush valid", 32'(bus.inst_valid), 32'd0);
    chk("coin enable off",  32'(bus.mem_enable), 32'd0);
    expect_inst("coin 0x40", 25'h40, 32'hA500_0040);

    // Misaligned redirect mid-request parks the fetcher once the drain completes.
    wait_enable("mis");
    step();
    redirect(25'h102);
    chk("mis fault set", 32'(bus.fetch_fault), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin seen |= bus.mem_enable; step(); end
    chk("mis no enable",  32'(seen), 32'd0);
    chk("mis no output",  32'(bus.inst_valid), 32'd0);
    chk("mis fault held", 32'(bus.fetch_fault), 32'd1);
    redirect(25'h200);
    chk("fix fault clr", 32'(bus.fetch_fault), 32'd0);
    expect_inst("fix 0x200", 25'h200, 32'hA500_0200);

    // Async reset mid-REQ; the orphaned response pulse lands while the fetcher is IDLE.
    n = 0;
    while (bus.mem_enable && n < 200) begin step(); n++; end
    n = 0;
    while (!bus.mem_enable && n < 200) begin step(); n++; end
    chk("ar enable rise", 32'(bus.mem_enable), 32'd1);
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar mem_enable",  32'(bus.mem_enable),  32'd0);
    chk("ar mem_addr",    32'(bus.mem_addr),    32'd0);
    chk("ar inst_valid",  32'(bus.inst_valid),  32'd0);
    chk("ar inst_pc",     32'(bus.inst_pc),     32'd0);
    chk("ar fetch_fault", 32'(bus.fetch_fault), 32'd0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b1;
    expect_inst("ar first", 25'h0, 32'hA500_0000);
    mon_en = 1'b1;

    // PC wrap at the top of the address space.
    redirect(25'h1FF_FFFC);
    expect_inst("wrap top", 25'h1FF_FFFC, 32'hA5FF_FFFC);
    expect_inst("wrap 0",   25'h0,        32'hA500_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
